// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter slice.
// Contents: requester tag enum, default bus widths and the default starvation limit.
package vram_pkg;

  // Identifies which requester owns an access or an in-flight read.
  typedef enum logic {
    TAG_DISP = 1'b0,
    TAG_HOST = 1'b1
  } vram_tag_e;

  localparam int unsigned VramAwDefault          = 17;
  localparam int unsigned VramDwDefault          = 8;
  localparam int unsigned VramStarveLimitDefault = 8;

endpackage

// File: rtl/vram_tag_pipe.sv
// Read-return tag pipeline: a Depth-deep valid+tag shift register whose output lines up with
// the VRAM read data of the access that pushed it.
// Ports:
//   clk_i    clock
//   clr_i    synchronous clear, drops every in-flight entry
//   valid_i  a read is being issued to the VRAM this cycle
//   tag_i    owner of that read
//   valid_o  the VRAM read data this cycle belongs to a tracked read
//   tag_o    owner of that read data
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  logic      valid_i,
  input  vram_tag_e tag_i,
  output logic      valid_o,
  output vram_tag_e tag_o
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] tag_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign tag_o   = vram_tag_e'(tag_q[Depth-1]);

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter sharing one single-port VRAM between the display line fetcher and the host port.
// Active video: display has priority, a starvation counter bounds the host wait.
// Blanking: round-robin between the two requesters.
// Read data is routed back to its issuer through a tag pipeline aligned with vram_rdata.
// Optional build macro VRAM_ARB_STATS_EN adds stats_clr, host_stall_cnt and grant_cnt.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   blank                            1 = blanking (round-robin), 0 = active video
//   disp_req/addr/gnt/rvalid/rdata   display read port
//   host_req/we/addr/wdata/gnt/rvalid/rdata  host read/write port
//   vram_en/we/addr/wdata/rdata      VRAM interface, issue one cycle after a grant
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned AW           = VramAwDefault,
  parameter int unsigned DW           = VramDwDefault,
  parameter int unsigned VRAM_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = VramStarveLimitDefault
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blank,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
`ifdef VRAM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   host_stall_cnt,
  output logic [15:0]   grant_cnt,
`endif
  output logic          vram_en,
  output logic          vram_we,
  output logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_wdata,
  input  logic [DW-1:0] vram_rdata
);

  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

  logic [WaitW-1:0] wait_q, wait_d;
  vram_tag_e        last_q, last_d;
  logic             en_q, we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  vram_tag_e        issue_tag_q;
  logic [DW-1:0]    disp_rdata_q, host_rdata_q;
  logic             host_wins;
  logic             ret_valid;
  vram_tag_e        ret_tag;

  // host_wins only matters when both request; a lone requester is always granted.
  always_comb begin
    host_wins = blank ? (last_q == TAG_DISP) : (wait_q == WaitMax);
    disp_gnt  = ~reset & disp_req & ~(host_req & host_wins);
    host_gnt  = ~reset & host_req & ~(disp_req & ~host_wins);
  end

  always_comb begin
    wait_d = wait_q;
    if (host_gnt) begin
      wait_d = '0;
    end else if (host_req && (wait_q != WaitMax)) begin
      wait_d = wait_q + 1'b1;
    end
    last_d = last_q;
    if (host_gnt) begin
      last_d = TAG_HOST;
    end else if (disp_gnt) begin
      last_d = TAG_DISP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q       <= '0;
      last_q       <= TAG_DISP;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      issue_tag_q  <= TAG_DISP;
      disp_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      wait_q      <= wait_d;
      last_q      <= last_d;
      en_q        <= disp_gnt | host_gnt;
      we_q        <= host_gnt & host_we;
      issue_tag_q <= host_gnt ? TAG_HOST : TAG_DISP;
      if (host_gnt) begin
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
      end else if (disp_gnt) begin
        addr_q <= disp_addr;
      end
      if (disp_rvalid) disp_rdata_q <= vram_rdata;
      if (host_rvalid) host_rdata_q <= vram_rdata;
    end
  end

  vram_tag_pipe #(
    .Depth (VRAM_LAT)
  ) u_tag_pipe (
    .clk_i   (clk),
    .clr_i   (reset),
    .valid_i (en_q & ~we_q),
    .tag_i   (issue_tag_q),
    .valid_o (ret_valid),
    .tag_o   (ret_tag)
  );

  // Reset gates the strobes in the same cycle so a pending issue or return is cancelled at once.
  assign vram_en     = en_q & ~reset;
  assign vram_we     = we_q & ~reset;
  assign vram_addr   = addr_q;
  assign vram_wdata  = wdata_q;
  assign disp_rvalid = ~reset & ret_valid & (ret_tag == TAG_DISP);
  assign host_rvalid = ~reset & ret_valid & (ret_tag == TAG_HOST);
  assign disp_rdata  = disp_rvalid ? vram_rdata : disp_rdata_q;
  assign host_rdata  = host_rvalid ? vram_rdata : host_rdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, gnt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      stall_cnt_q <= '0;
      gnt_cnt_q   <= '0;
    end else begin
      if (host_req && !host_gnt && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((disp_gnt || host_gnt) && (gnt_cnt_q != 16'hFFFF)) gnt_cnt_q <= gnt_cnt_q + 1'b1;
    end
  end

  assign host_stall_cnt = stall_cnt_q;
  assign grant_cnt      = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level reference (grant rules, expected-read queue, reference memory).
module tb_vram_arbiter;

  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset, blank;
  logic          disp_req, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          vram_en, vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata, vram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic          stats_clr;
  logic [15:0]   host_stall_cnt, grant_cnt;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .VRAM_LAT     (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .blank          (blank),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rvalid    (disp_rvalid),
    .disp_rdata     (disp_rdata),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_gnt       (host_gnt),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
`ifdef VRAM_ARB_STATS_EN
    .stats_clr      (stats_clr),
    .host_stall_cnt (host_stall_cnt),
    .grant_cnt      (grant_cnt),
`endif
    .vram_en        (vram_en),
    .vram_we        (vram_we),
    .vram_addr      (vram_addr),
    .vram_wdata     (vram_wdata),
    .vram_rdata     (vram_rdata)
  );

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
  endfunction

  // VRAM environment: LAT-cycle read latency, garbage on the bus when no read returns.
  logic [7:0] env_mem [0:(1<<AW)-1];
  bit         env_wr  [0:(1<<AW)-1];
  logic [7:0] rd_sh   [LAT];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_sh[i] <= rd_sh[i-1];
    if (vram_en && !vram_we) rd_sh[0] <= env_wr[vram_addr] ? env_mem[vram_addr] : pat(vram_addr);
    else rd_sh[0] <= 8'($urandom);
    if (vram_en && vram_we) begin
      env_mem[vram_addr] <= vram_wdata;
      env_wr[vram_addr]  <= 1'b1;
    end
  end
  assign vram_rdata = rd_sh[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {bit host; int due; logic [7:0] data;} rd_t;
  rd_t        rdq[$];
  logic [7:0] ref_mem [logic [AW-1:0]];
  int         m_wait;
  bit         m_last_host;
  logic [7:0] m_drd, m_hrd;
  bit         iss_v, iss_we;
  logic [AW-1:0] iss_addr;
  logic [7:0] iss_wdata;
  int         st_stall, st_grant;
  int         cyc;
  // Observations of the DUT
  bit         o_d, o_h;
  int         hg_cyc, h_rv_cyc, h_rv_count, rv_total;
  logic [7:0] h_rv_data;
  int         d_pulses, d_first, d_last;
  int         host_wait_run, host_wait_max;

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  task automatic tick();
    bit hw, ed, eh, ev_d, ev_h;
    @(negedge clk);
    ed = 1'b0;
    eh = 1'b0;
    if (!reset) begin
      hw = blank ? !m_last_host : (m_wait >= int'(LIMIT));
      ed = disp_req && !(host_req && hw);
      eh = host_req && !(disp_req && !hw);
    end
    check("disp_gnt", disp_gnt, ed);
    check("host_gnt", host_gnt, eh);
    check("vram_en", vram_en, iss_v && !reset);
    if (iss_v && !reset) begin
      check("vram_we", vram_we, iss_we);
      check("vram_addr", vram_addr, iss_addr);
      if (iss_we) check("vram_wdata", vram_wdata, iss_wdata);
    end
    ev_d = 1'b0;
    ev_h = 1'b0;
    if (!reset && rdq.size() > 0 && rdq[0].due == cyc) begin
      if (rdq[0].host) begin ev_h = 1'b1; m_hrd = rdq[0].data; end
      else begin ev_d = 1'b1; m_drd = rdq[0].data; end
      void'(rdq.pop_front());
    end
    check("disp_rvalid", disp_rvalid, ev_d);
    check("host_rvalid", host_rvalid, ev_h);
    if (!reset) begin
      check("disp_rdata", disp_rdata, m_drd);
      check("host_rdata", host_rdata, m_hrd);
    end
`ifdef VRAM_ARB_STATS_EN
    check("host_stall_cnt", host_stall_cnt, st_stall);
    check("grant_cnt", grant_cnt, st_grant);
`endif
    o_d = disp_gnt;
    o_h = host_gnt;
    if (host_gnt) hg_cyc = cyc;
    if (host_rvalid) begin h_rv_cyc = cyc; h_rv_data = host_rdata; h_rv_count++; end
    if (disp_rvalid) begin
      if (d_pulses == 0) d_first = cyc;
      d_last = cyc;
      d_pulses++;
    end
    if (disp_rvalid || host_rvalid) rv_total++;
    if (!reset && host_req && !host_gnt) host_wait_run++;
    else host_wait_run = 0;
    if (host_wait_run > host_wait_max) host_wait_max = host_wait_run;
    // Advance the reference
    if (reset) begin
      m_wait = 0; m_last_host = 1'b0; rdq.delete();
      m_drd = '0; m_hrd = '0; iss_v = 1'b0; st_stall = 0; st_grant = 0;
    end else begin
      if (eh) m_wait = 0;
      else if (host_req && m_wait < int'(LIMIT)) m_wait++;
      if (ed) m_last_host = 1'b0;
      if (eh) m_last_host = 1'b1;
      iss_v     = ed || eh;
      iss_we    = eh && host_we;
      iss_addr  = eh ? host_addr : disp_addr;
      iss_wdata = host_wdata;
      if (ed) rdq.push_back('{host: 1'b0, due: cyc + 1 + int'(LAT), data: ref_rd(disp_addr)});
      if (eh && !host_we)
        rdq.push_back('{host: 1'b1, due: cyc + 1 + int'(LAT), data: ref_rd(host_addr)});
      if (eh && host_we) ref_mem[host_addr] = host_wdata;
`ifdef VRAM_ARB_STATS_EN
      if (stats_clr) begin st_stall = 0; st_grant = 0; end
      else begin
        if (host_req && !eh) st_stall++;
        if (ed || eh) st_grant++;
      end
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Both requesters stay busy in active video: host must wait exactly LIMIT cycles.
  task automatic run_starve(input string tag);
    int nd, guard;
    bit got_h;
    blank = 1'b0; disp_req = 1'b1; disp_addr = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00100;
    nd = 0; guard = 0; got_h = 1'b0; h_rv_cyc = -1;
    while (!got_h && guard < 30) begin
      tick();
      guard++;
      if (o_d) begin nd++; disp_addr = disp_addr + 1'b1; end
      if (o_h) got_h = 1'b1;
    end
    disp_req = 1'b0; host_req = 1'b0;
    check({tag, "_host_granted"}, got_h, 1);
    check({tag, "_disp_before_host"}, nd, LIMIT);
`ifdef VRAM_ARB_STATS_EN
    check({tag, "_stall_cnt"}, host_stall_cnt, 8);
    check({tag, "_grant_cnt"}, grant_cnt, 9);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check({tag, "_stall_clr"}, host_stall_cnt, 0);
    check({tag, "_grant_clr"}, grant_cnt, 0);
`endif
    repeat (LAT + 2) tick();
    check({tag, "_host_latency"}, h_rv_cyc - hg_cyc, 1 + LAT);
    check({tag, "_host_data"}, h_rv_data, pat(17'h00100));
  endtask

  task automatic drain();
    disp_req = 1'b0; host_req = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    int ng, prev, viol, guard;
    reset = 1'b1; blank = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    cyc = 0; m_drd = '0; m_hrd = '0; iss_v = 1'b0; m_wait = 0; m_last_host = 1'b0;
    st_stall = 0; st_grant = 0; h_rv_count = 0; rv_total = 0; d_pulses = 0;
    d_first = 0; d_last = 0; host_wait_run = 0; host_wait_max = 0; hg_cyc = 0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_vram_we", vram_we, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_vram_wdata", vram_wdata, 0);
    check("rst_disp_rdata", disp_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);

    run_starve("s1");

    // Blanking: strict alternation, host never waits more than one cycle.
    blank = 1'b1; disp_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
    disp_addr = AW'($urandom); host_addr = AW'($urandom);
    ng = 0; prev = -1; viol = 0; host_wait_max = 0;
    repeat (20) begin
      tick();
      if (o_d) begin
        ng++; if (prev == 0) viol++; prev = 0; disp_addr = AW'($urandom);
      end
      if (o_h) begin
        ng++; if (prev == 1) viol++; prev = 1; host_addr = AW'($urandom);
      end
    end
    drain();
    check("s2_grants", ng, 20);
    check("s2_alternation_errors", viol, 0);
    check("s2_host_wait_le1", host_wait_max <= 1, 1);

    // Host write at the top address, then display read of it.
    blank = 1'b0; h_rv_count = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h1FFFF; host_wdata = 8'hA5;
    guard = 0; o_h = 1'b0;
    while (!o_h && guard < 10) begin tick(); guard++; end
    check("s3_write_granted", o_h, 1);
    host_req = 1'b0; host_we = 1'b0;
    disp_req = 1'b1; disp_addr = 17'h1FFFF;
    guard = 0; o_d = 1'b0;
    while (!o_d && guard < 10) begin tick(); guard++; end
    drain();
    check("s3_disp_rdata", disp_rdata, 8'hA5);
    check("s3_no_host_rvalid", h_rv_count, 0);

    // Back-to-back display reads 0..15.
    d_pulses = 0; disp_req = 1'b1; disp_addr = '0; ng = 0; guard = 0;
    while (ng < 16 && guard < 40) begin
      tick();
      guard++;
      if (o_d) begin ng++; disp_addr = disp_addr + 1'b1; end
      if (ng == 16) disp_req = 1'b0;
    end
    drain();
    check("s4_pulses", d_pulses, 16);
    check("s4_span", d_last - d_first, 15);

    // Reset with two reads in flight.
    disp_req = 1'b1; disp_addr = 17'h00040; ng = 0; guard = 0;
    while (ng < 2 && guard < 10) begin
      tick();
      guard++;
      if (o_d) begin ng++; disp_addr = disp_addr + 1'b1; end
    end
    disp_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rv_total = 0;
    repeat (LAT + 3) tick();
    check("s5_no_rvalid", rv_total, 0);
    run_starve("s5");

    // Random mixed traffic.
    repeat (600) begin
      if ($urandom_range(9) == 0) blank = ~blank;
      if (!disp_req || o_d) begin
        disp_req  = ($urandom_range(99) < 60);
        disp_addr = AW'($urandom_range(0, 63));
      end
      if (!host_req || o_h) begin
        host_req   = ($urandom_range(99) < 45);
        host_we    = 1'($urandom_range(1));
        host_addr  = AW'($urandom_range(0, 63));
        host_wdata = 8'($urandom);
      end
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port VRAM between two requesters: the display line fetcher, which feeds the timing/pattern generator, and the host register/bus port.
- During active video the display fetcher has priority; a starvation counter guarantees the host a bounded wait.
- During blanking, grants alternate round-robin.
- Read data is returned to whichever requester issued the read, using a tagged latency pipeline.

Parameters:
- AW, 17, VRAM address width.
- DW, 8, VRAM data width.
- VRAM_LAT, 1, VRAM read latency in cycles, from vram_en to valid vram_rdata (1..4).
- STARVE_LIMIT, 8, consecutive denied host cycles before the host is forced a grant (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- blank  in  1  HBlank|VBlank from the timing generator; 1 selects round-robin mode
- disp_req  in  1  display read request
- disp_addr  in  AW  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DW  display read data
- host_req  in  1  host access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DW  host read data
- vram_en  out  1  VRAM access strobe
- vram_we  out  1  VRAM write enable
- vram_addr  out  AW  VRAM address
- vram_wdata  out  DW  VRAM write data
- vram_rdata  in  DW  VRAM read data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - wait_cnt = 0.
  - last_grant = DISP.
  - Tag pipeline cleared.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - gnt is combinational from req and arbiter state. At most one gnt per cycle.
  - Sampled on the gnt edge; the requester may change its fields in the following cycle.
- Issue stage (registered): in the cycle after a gnt, vram_en=1 and vram_we/addr/wdata take the granted requester's values. Otherwise vram_en=0 and vram_we=0.
- Read return:
  - Each issued read pushes a tag (DISP/HOST) into a VRAM_LAT-deep shift register aligned with vram_rdata.
  - At the output, the matching *_rvalid pulses for 1 cycle with *_rdata = vram_rdata.
  - Writes push no tag.
  - Total read latency from gnt: 1+VRAM_LAT cycles.
- *_rdata holds its last value when rvalid=0.
- Arbitration modes:
  - Active mode (blank=0):
    - If both request and wait_cnt < STARVE_LIMIT: display wins.
    - If both request and wait_cnt == STARVE_LIMIT: host wins.
  - Blank mode (blank=1): if both request, the requester that is not last_grant wins.
  - Single requester: always granted, in either mode.
- Starvation counter:
  - wait_cnt increments, saturating at STARVE_LIMIT, each cycle with host_req=1 and host_gnt=0.
  - Clears on host_gnt.
  - Holds while host_req=0.
- last_grant updates on every gnt.
- blank changes take effect in the same cycle; no grant is ever dropped or duplicated at a mode switch.
- Reset mid-operation: in-flight reads are discarded, no rvalid is emitted for them, and the pending VRAM issue is cancelled (vram_en=0).

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs host_stall_cnt[15:0] (cycles with host_req && !host_gnt) and grant_cnt[15:0] (total gnts).
  - Both saturate at 16'hFFFF.
  - Both clear on reset or on the added input stats_clr (1 bit, synchronous).
- Undefined: the ports and counters are absent; arbitration is identical.

Decomposition:
- Shared package vram_pkg holds:
  - the grant tag enum (TAG_DISP=0, TAG_HOST=1);
  - default AW/DW constants;
  - the STARVE_LIMIT default.
- One sub-module: vram_tag_pipe, a VRAM_LAT-deep valid+tag shift register with synchronous clear.

Test Plan:
- Reset released, blank=0, disp_req=1 continuously, host_req=1 read at 0x00100:
  - display granted cycles 0..7, host granted cycle 8;
  - host_rvalid exactly 1+VRAM_LAT cycles after host_gnt, carrying mem[0x00100].
- blank=1, both requesting continuously: grants alternate DISP, HOST, DISP, HOST…; wait_cnt never exceeds 1.
- Host write 0xA5 to 0x1FFFF, then display read of 0x1FFFF: disp_rdata=0xA5; host_rvalid never pulses for the write.
- Back-to-back display reads of addresses 0..15 with VRAM_LAT=3: 16 disp_rvalid pulses, data in issue order, no gaps.
- Assert reset while 2 reads are in flight: no rvalid afterwards; wait_cnt=0; next grant behaves as from power-up.
- With VRAM_ARB_STATS_EN and the first scenario: host_stall_cnt=8, grant_cnt=9; stats_clr zeroes both the next cycle.
